// File: rtl/execute_sequencer_if.sv
// Decode-to-execute issue handshake plus the per-cycle execute-stage control strobes.
interface execute_sequencer_if;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_mul;
    logic [2:0]  issue_type;
    logic [3:0]  issue_dest;
    logic [3:0]  issue_dest_hi;
    logic        issue_set_cpsr;
    logic        exec;
    logic [31:0] do_cycle;
    logic [31:0] m_ma_cycle;
    logic [2:0]  op_type;
    logic [3:0]  dest;
    logic        write_dest_do;
    logic        write_dest_m;
    logic        wb_hi;
    logic        write_cpsr;
    logic        busy;

    modport master (
        output flush, issue_valid, issue_mul, issue_type, issue_dest, issue_dest_hi,
               issue_set_cpsr,
        input  issue_ready, exec, do_cycle, m_ma_cycle, op_type, dest, write_dest_do,
               write_dest_m, wb_hi, write_cpsr, busy
    );

    modport slave (
        input  flush, issue_valid, issue_mul, issue_type, issue_dest, issue_dest_hi,
               issue_set_cpsr,
        output issue_ready, exec, do_cycle, m_ma_cycle, op_type, dest, write_dest_do,
               write_dest_m, wb_hi, write_cpsr, busy
    );
endinterface

// File: rtl/execute_sequencer.sv
// Execute-stage sequencer: accepts one decoded op per handshake and steps the ALU or
// multiplier through compute and writeback cycles; all strobes decode from registered state.
module execute_sequencer #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned MLA_CYCLES = 3,
    parameter int unsigned LONG_EXTRA = 1
) (
    input logic                clk,
    input logic                rst,
    execute_sequencer_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StDo, StMul, StWbLo, StWbHi} state_e;

    // Counter preload is N-1 so that the MUL state lasts exactly N cycles.
    localparam logic [3:0] LdMul  = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] LdMla  = 4'(MLA_CYCLES - 1);
    localparam logic [3:0] LdMulL = 4'(MUL_CYCLES + LONG_EXTRA - 1);
    localparam logic [3:0] LdMlaL = 4'(MLA_CYCLES + LONG_EXTRA - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] type_q;
    logic [3:0] dest_q, dest_hi_q;
    logic       cpsr_q;
    logic       long_q;
    logic       final_wb;
    logic       ready;
    logic       accept;
    logic [3:0] cnt_load;

    assign long_q   = type_q[2];
    assign final_wb = (state_q == StWbLo && !long_q) || state_q == StWbHi;
    assign ready    = !rst && (state_q == StIdle || state_q == StDo || final_wb);
    assign accept   = bus.issue_valid && ready && !bus.flush;

    always_comb begin
        unique case ({bus.issue_type[2], bus.issue_type[0]})
            2'b00:   cnt_load = LdMul;
            2'b01:   cnt_load = LdMla;
            2'b10:   cnt_load = LdMulL;
            default: cnt_load = LdMlaL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StMul: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWbLo;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWbLo:  state_d = long_q ? StWbHi : StIdle;
            default: state_d = StIdle;
        endcase
        // A new op can follow DO or the final writeback with no bubble.
        if (accept) begin
            state_d = bus.issue_mul ? StMul : StDo;
            cnt_d   = bus.issue_mul ? cnt_load : 4'd0;
        end
        if (bus.flush) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            type_q    <= 3'd0;
            dest_q    <= 4'd0;
            dest_hi_q <= 4'd0;
            cpsr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                type_q    <= bus.issue_type;
                dest_q    <= bus.issue_dest;
                dest_hi_q <= bus.issue_dest_hi;
                cpsr_q    <= bus.issue_set_cpsr;
            end
        end
    end

    always_comb begin
        bus.issue_ready   = ready;
        bus.op_type       = type_q;
        bus.dest          = dest_q;
        bus.exec          = 1'b0;
        bus.do_cycle      = 32'd0;
        bus.m_ma_cycle    = 32'd0;
        bus.write_dest_do = 1'b0;
        bus.write_dest_m  = 1'b0;
        bus.wb_hi         = 1'b0;
        bus.write_cpsr    = 1'b0;
        bus.busy          = state_q != StIdle;
        unique case (state_q)
            StDo: begin
                bus.exec          = 1'b1;
                bus.do_cycle      = 32'd1;
                bus.write_dest_do = 1'b1;
                bus.write_cpsr    = cpsr_q;
            end
            StMul: begin
                bus.exec       = 1'b1;
                bus.m_ma_cycle = 32'd1;
            end
            StWbLo: begin
                bus.exec         = 1'b1;
                bus.write_dest_m = 1'b1;
                // Long multiplies update flags with the high word instead.
                bus.write_cpsr   = cpsr_q && !long_q;
            end
            StWbHi: begin
                bus.write_dest_m = 1'b1;
                bus.dest         = dest_hi_q;
                bus.wb_hi        = 1'b1;
                bus.write_cpsr   = cpsr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_execute_sequencer.sv
// Directed bench for execute_sequencer: each step queues the expected post-edge outputs
// and checks them one time unit after the clock edge.
module tb_execute_sequencer;

    typedef struct packed {
        logic        exec;
        logic [31:0] do_cycle;
        logic [31:0] m_ma;
        logic [2:0]  ty;
        logic        dcare;
        logic [3:0]  dest;
        logic        wdo;
        logic        wdm;
        logic        wbhi;
        logic        wcpsr;
        logic        busy;
        logic        ready;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    execute_sequencer_if bus ();

    execute_sequencer #(
        .MUL_CYCLES(2),
        .MLA_CYCLES(3),
        .LONG_EXTRA(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic ex, input logic dc, input logic mm,
                                input logic [2:0] ty, input logic dcare, input logic [3:0] d,
                                input logic wdo, input logic wdm, input logic wbhi,
                                input logic wc, input logic bsy, input logic rdy);
        exp_t e;
        e.exec = ex;  e.do_cycle = {31'd0, dc};  e.m_ma = {31'd0, mm};
        e.ty = ty;    e.dcare = dcare;  e.dest = d;
        e.wdo = wdo;  e.wdm = wdm;  e.wbhi = wbhi;  e.wcpsr = wc;
        e.busy = bsy; e.ready = rdy;
        return e;
    endfunction

    function automatic exp_t e_rst();
        return mk(0, 0, 0, 3'd0, 1, 4'd0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic exp_t e_idle(input logic [2:0] ty);
        return mk(0, 0, 0, ty, 0, 4'd0, 0, 0, 0, 0, 0, 1);
    endfunction
    function automatic exp_t e_do(input logic [2:0] ty, input logic [3:0] d, input logic c);
        return mk(1, 1, 0, ty, 1, d, 1, 0, 0, c, 1, 1);
    endfunction
    function automatic exp_t e_mul(input logic [2:0] ty);
        return mk(1, 0, 1, ty, 0, 4'd0, 0, 0, 0, 0, 1, 0);
    endfunction
    function automatic exp_t e_lo(input logic [2:0] ty, input logic [3:0] d, input logic c,
                                  input logic rdy);
        return mk(1, 0, 0, ty, 1, d, 0, 1, 0, c, 1, rdy);
    endfunction
    function automatic exp_t e_hi(input logic [2:0] ty, input logic [3:0] d, input logic c);
        return mk(0, 0, 0, ty, 1, d, 0, 1, 1, c, 1, 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic fl, input logic v, input logic mul,
                        input logic [2:0] ty, input logic [3:0] d, input logic [3:0] dh,
                        input logic c, input exp_t e);
        exp_t x;
        rst                = r;
        bus.flush          = fl;
        bus.issue_valid    = v;
        bus.issue_mul      = mul;
        bus.issue_type     = ty;
        bus.issue_dest     = d;
        bus.issue_dest_hi  = dh;
        bus.issue_set_cpsr = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("exec", 32'(bus.exec), 32'(x.exec));
        chk("do_cycle", bus.do_cycle, x.do_cycle);
        chk("m_ma_cycle", bus.m_ma_cycle, x.m_ma);
        chk("type", 32'(bus.op_type), 32'(x.ty));
        if (x.dcare) chk("dest", 32'(bus.dest), 32'(x.dest));
        chk("write_dest_do", 32'(bus.write_dest_do), 32'(x.wdo));
        chk("write_dest_m", 32'(bus.write_dest_m), 32'(x.wdm));
        chk("wb_hi", 32'(bus.wb_hi), 32'(x.wbhi));
        chk("write_cpsr", 32'(bus.write_cpsr), 32'(x.wcpsr));
        chk("busy", 32'(bus.busy), 32'(x.busy));
        chk("issue_ready", 32'(bus.issue_ready), 32'(x.ready));
    endtask

    task automatic idle(input exp_t e);
        step(0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 0, e);
    endtask

    initial begin
        // Reset, then a single flag-setting data op.
        step(1, 0, 0, 0, 3'd0, 4'd0, 4'd0, 0, e_rst());
        idle(e_idle(3'd0));
        step(0, 0, 1, 0, 3'd0, 4'd5, 4'd0, 1, e_do(3'd0, 4'd5, 1));
        idle(e_idle(3'd0));

        // MUL: two compute cycles then WB_LO.
        step(0, 0, 1, 1, 3'd0, 4'd3, 4'd0, 0, e_mul(3'd0));
        idle(e_mul(3'd0));
        idle(e_lo(3'd0, 4'd3, 0, 1));
        idle(e_idle(3'd0));

        // UMLAL: 3+1 compute cycles, WB_LO without flags, WB_HI with flags.
        step(0, 0, 1, 1, 3'b101, 4'd2, 4'd7, 1, e_mul(3'b101));
        repeat (3) idle(e_mul(3'b101));
        idle(e_lo(3'b101, 4'd2, 0, 0));
        idle(e_hi(3'b101, 4'd7, 1));
        idle(e_idle(3'b101));

        // Short MLA: three compute cycles, flags written in WB_LO.
        step(0, 0, 1, 1, 3'b001, 4'd10, 4'd0, 1, e_mul(3'b001));
        repeat (2) idle(e_mul(3'b001));
        idle(e_lo(3'b001, 4'd10, 1, 1));
        idle(e_idle(3'b001));

        // Back-to-back data ops.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 3'd0, 4'(i + 1), 4'd0, i[0], e_do(3'd0, 4'(i + 1), i[0]));
        end
        idle(e_idle(3'd0));

        // Flush during the second MUL cycle: no writeback afterwards.
        step(0, 0, 1, 1, 3'd0, 4'd9, 4'd0, 1, e_mul(3'd0));
        idle(e_mul(3'd0));
        step(0, 1, 0, 0, 3'd0, 4'd0, 4'd0, 0, e_idle(3'd0));
        repeat (2) idle(e_idle(3'd0));

        // Flush wins over a simultaneous accept.
        step(0, 0, 1, 0, 3'd0, 4'd12, 4'd0, 0, e_do(3'd0, 4'd12, 0));
        step(0, 1, 1, 0, 3'd0, 4'd13, 4'd0, 1, e_idle(3'd0));
        idle(e_idle(3'd0));

        // UMULL interrupted by reset in WB_HI.
        step(0, 0, 1, 1, 3'b100, 4'd4, 4'd6, 1, e_mul(3'b100));
        repeat (2) idle(e_mul(3'b100));
        idle(e_lo(3'b100, 4'd4, 0, 0));
        idle(e_hi(3'b100, 4'd6, 1));
        step(1, 0, 0, 0, 3'd0, 4'd0, 4'd0, 0, e_rst());
        idle(e_idle(3'd0));

        // Data op held by decode across a MUL is taken straight after WB_LO.
        step(0, 0, 1, 1, 3'd0, 4'd8, 4'd0, 0, e_mul(3'd0));
        step(0, 0, 1, 0, 3'd0, 4'd11, 4'd0, 0, e_mul(3'd0));
        step(0, 0, 1, 0, 3'd0, 4'd11, 4'd0, 0, e_lo(3'd0, 4'd8, 0, 1));
        step(0, 0, 1, 0, 3'd0, 4'd11, 4'd0, 0, e_do(3'd0, 4'd11, 0));
        idle(e_idle(3'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
